pdm_capture_ctrl: RTL and testbench

- Sequences a PDM microphone capture: enables the PDM clock generator, discards a mic warm-up interval, deserialises PDM bits into DATA_WIDTH-bit words and streams them to the AXI-Stream FIFO with TLAST on the final word.
- Sits between the PS control registers (start/stop/length/status) and the pdm_clk_gen + AXI FIFO datapath.
- Runs on the single 100 MHz fabric clock; the PDM bit rate is set only by the m_clk_rising enable strobe.

---
 rtl/pdm_capture_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_pdm_capture_ctrl.sv | 516 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_capture_ctrl.sv
// pdm_capture_ctrl
//   Sequences one PDM microphone capture. It enables the PDM clock generator,
//   throws away the mic warm-up interval, packs PDM bits MSB first into
//   DATA_WIDTH-bit words and streams them out over AXI-Stream. TLAST is set on
//   the final word.
//
// Ports
//   clk            fabric clock
//   rst            asynchronous reset, active low
//   start          one-cycle pulse, begins a capture (only accepted in IDLE)
//   stop           one-cycle pulse, aborts a capture (wins over start)
//   num_words      words to capture, latched on an accepted start
//   m_clk_rising   bit-enable strobe from the clock generator
//   pdm_data       asynchronous microphone data
//   clkgen_rstn    active-low reset/enable to the clock generator
//   m_axis_*       AXI-Stream master (tdata/tvalid/tready/tlast)
//   busy           high in every state except IDLE and DONE
//   done           one-cycle pulse while in DONE
//   overflow       sticky, a completed word was dropped; cleared on start
module pdm_capture_ctrl #(
    parameter int DATA_WIDTH   = 16,
    parameter int CNT_WIDTH    = 16,
    parameter int WARMUP_EDGES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [CNT_WIDTH-1:0]  num_words,
    input  logic                  m_clk_rising,
    input  logic                  pdm_data,
    output logic                  clkgen_rstn,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0]        BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0]        BIT_ONE   = BW'(1);
    localparam logic [CNT_WIDTH-1:0] WARM_LAST = CNT_WIDTH'(WARMUP_EDGES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_CAPTURE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic                  pdm_p0, pdm_p1;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  warm_cnt;
    logic [CNT_WIDTH-1:0]  words_sent;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_last;
    logic                  hold_vld;
    logic                  overflow_q;

    logic                  start_ok;
    logic                  beat_acc;
    logic                  word_done;
    logic                  load;
    logic                  load_last;
    logic [DATA_WIDTH-1:0] word_full;

    assign start_ok  = start && !stop;
    assign beat_acc  = hold_vld && m_axis_tready;
    assign word_full = {shift_q[DATA_WIDTH-2:0], pdm_p1};
    // A stop in the same cycle discards the word being completed.
    assign word_done = (state == S_CAPTURE) && m_clk_rising && !stop
                       && (bit_cnt == BIT_LAST);
    // The holding register takes a new word when empty or draining this cycle.
    assign load      = word_done && (!hold_vld || beat_acc);
    assign load_last = load && (words_sent == len_q - CNT_ONE);

    assign m_axis_tdata  = hold_data;
    assign m_axis_tvalid = hold_vld;
    assign m_axis_tlast  = hold_last;
    assign overflow      = overflow_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        clkgen_rstn = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_next = (num_words == '0) ? S_DONE : S_WARMUP;
                end
            end
            S_WARMUP: begin
                clkgen_rstn = 1'b1;
                busy        = 1'b1;
                if (stop) begin
                    state_next = S_FLUSH;
                end else if (m_clk_rising && (warm_cnt == WARM_LAST)) begin
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                clkgen_rstn = 1'b1;
                busy        = 1'b1;
                if (stop || load_last) begin
                    state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy = 1'b1;
                if (!hold_vld) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pdm_p0     <= 1'b0;
            pdm_p1     <= 1'b0;
            len_q      <= '0;
            warm_cnt   <= '0;
            words_sent <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
            hold_data  <= '0;
            hold_last  <= 1'b0;
            hold_vld   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            // Stage p0 -> p1: two-flop synchroniser for the mic data
            pdm_p0 <= pdm_data;
            pdm_p1 <= pdm_p0;

            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        len_q      <= num_words;
                        overflow_q <= 1'b0;
                        warm_cnt   <= '0;
                        words_sent <= '0;
                        bit_cnt    <= '0;
                        shift_q    <= '0;
                    end
                end
                S_WARMUP: begin
                    if (!stop && m_clk_rising && (warm_cnt != WARM_LAST)) begin
                        warm_cnt <= warm_cnt + CNT_ONE;
                    end
                end
                S_CAPTURE: begin
                    if (stop) begin
                        bit_cnt <= '0;
                        shift_q <= '0;
                    end else if (m_clk_rising) begin
                        shift_q <= word_full;
                        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_ONE;
                    end
                end
                default: begin
                end
            endcase

            if (load) begin
                hold_data <= word_full;
                hold_last <= load_last;
                hold_vld  <= 1'b1;
                if (words_sent != '1) begin
                    words_sent <= words_sent + CNT_ONE;
                end
            end else if (beat_acc) begin
                hold_vld <= 1'b0;
            end

            if (word_done && !load) begin
                overflow_q <= 1'b1;
            end

            // An aborted capture closes the stream on whatever word is pending.
            if (stop && hold_vld && ((state == S_WARMUP) || (state == S_CAPTURE))) begin
                hold_last <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
module tb_pdm_capture_ctrl;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int WE = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic          stop;
    logic [CW-1:0] num_words;
    logic          m_clk_rising;
    logic          pdm_data;
    logic          clkgen_rstn;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          busy;
    logic          done;
    logic          overflow;

    pdm_capture_ctrl #(
        .DATA_WIDTH  (DW),
        .CNT_WIDTH   (CW),
        .WARMUP_EDGES(WE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .num_words    (num_words),
        .m_clk_rising (m_clk_rising),
        .pdm_data     (pdm_data),
        .clkgen_rstn  (clkgen_rstn),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int tr_mode = 1;  // 0: tready low, 1: tready high, 2: random

    // Stream monitor: records every accepted beat and watches handshake rules.
    int            done_cnt = 0;
    int            stab_err = 0;
    int            busy_done_err = 0;
    logic [DW-1:0] beat_d[$];
    logic          beat_l[$];
    logic          prev_v = 1'b0;
    logic          prev_r = 1'b0;
    logic [DW-1:0] prev_d = '0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_v <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                beat_d.push_back(m_axis_tdata);
                beat_l.push_back(m_axis_tlast);
            end
            if (prev_v && !prev_r && (!m_axis_tvalid || m_axis_tdata !== prev_d))
                stab_err <= stab_err + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (done && busy) busy_done_err <= busy_done_err + 1;
            prev_v <= m_axis_tvalid;
            prev_r <= m_axis_tready;
            prev_d <= m_axis_tdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (tr_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = ($urandom_range(3) != 0);
        endcase
    endtask

    // Holds the bit for period-1 cycles (covers the synchroniser), then strobes.
    task automatic send_bit(input logic b, input int period);
        pdm_data = b;
        repeat (period - 1) tick();
        m_clk_rising = 1'b1;
        tick();
        m_clk_rising = 1'b0;
    endtask

    task automatic send_bits(input logic [DW-1:0] w, input int hi, input int lo, input int period);
        for (int i = hi; i >= lo; i--) send_bit(w[i], period);
    endtask

    task automatic send_warmup(input int period);
        for (int i = 0; i < WE; i++) send_bit(1'($urandom_range(1)), period);
    endtask

    task automatic pulse_start(input logic [CW-1:0] n);
        num_words = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, output bit ok, output int cyc);
        cyc = 0;
        while (done_cnt == base && cyc < budget) begin
            tick();
            cyc++;
        end
        ok = (done_cnt != base);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({clkgen_rstn, m_axis_tvalid, m_axis_tlast, busy, done, overflow} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {clkgen_rstn, m_axis_tvalid, m_axis_tlast, busy, done, overflow});
        end
        n_tests++;
        if (m_axis_tdata !== '0) begin
            n_fail++;
            $display("FAIL reset_tdata: got %h expected 0000", m_axis_tdata);
        end
        rst = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        int  b0 = beat_d.size();
        int  d0 = done_cnt;
        int  cyc;
        bit  ok;
        n_tests++;
        if (clkgen_rstn !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_clkgen_idle: got %b expected 0", clkgen_rstn);
        end
        pulse_start(16'd4);
        n_tests++;
        if (clkgen_rstn !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_clkgen_on: got %b%b expected 11", clkgen_rstn, busy);
        end
        for (int i = 0; i < WE; i++) send_bit(1'(i % 2 == 0), 40);
        send_bits(16'hAAAA, 15, 1, 40);
        n_tests++;
        if (beat_d.size() - b0 !== 0 || m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_warmup_discard: got %0d beats expected 0", beat_d.size() - b0);
        end
        send_bits(16'hAAAA, 0, 0, 40);
        for (int w = 1; w < 4; w++) send_bits(16'hAAAA, 15, 0, 40);
        wait_done(d0, 20, ok, cyc);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL basic_done_timeout: got no done expected done within 20 cycles");
        end
        tick();
        n_tests++;
        if (beat_d.size() - b0 !== 4) begin
            n_fail++;
            $display("FAIL basic_beat_count: got %0d expected 4", beat_d.size() - b0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (beat_d[b0+i] !== 16'hAAAA || beat_l[b0+i] !== (i == 3)) begin
                    n_fail++;
                    $display("FAIL basic_beat%0d: got %h/%b expected aaaa/%b",
                             i, beat_d[b0+i], beat_l[b0+i], (i == 3));
                end
            end
        end
        n_tests++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0 || busy_done_err !== 0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: got %0d pulses busy=%b overlap=%0d expected 1 0 0",
                     done_cnt - d0, busy, busy_done_err);
        end
    endtask

    task automatic test_overflow();
        int  b0 = beat_d.size();
        int  d0 = done_cnt;
        int  cyc;
        bit  ok;
        tr_mode = 0;
        tick();
        pulse_start(16'd2);
        send_warmup(3);
        send_bits(16'hFFFF, 15, 0, 3);
        repeat (2) tick();
        n_tests++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'hFFFF || m_axis_tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_word1_held: got %b/%h/%b expected 1/ffff/0",
                     m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
        send_bits(16'hFFFF, 15, 0, 3);
        tick();
        n_tests++;
        if (overflow !== 1'b1 || m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_drop: got ovf=%b vld=%b last=%b expected 1 1 0",
                     overflow, m_axis_tvalid, m_axis_tlast);
        end
        send_bits(16'hFFFF, 15, 1, 3);
        tr_mode = 1;
        send_bits(16'hFFFF, 0, 0, 3);
        wait_done(d0, 20, ok, cyc);
        tick();
        n_tests++;
        if (!ok || beat_d.size() - b0 !== 2) begin
            n_fail++;
            $display("FAIL ovf_beats: got %0d beats done=%b expected 2 1", beat_d.size() - b0, ok);
        end else begin
            n_tests++;
            if (beat_d[b0] !== 16'hFFFF || beat_l[b0] !== 1'b0 ||
                beat_d[b0+1] !== 16'hFFFF || beat_l[b0+1] !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_tlast: got %h/%b %h/%b expected ffff/0 ffff/1",
                         beat_d[b0], beat_l[b0], beat_d[b0+1], beat_l[b0+1]);
            end
        end
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %b expected 1", overflow);
        end
    endtask

    task automatic test_stop();
        logic [DW-1:0] w[3];
        int  b0 = beat_d.size();
        int  d0 = done_cnt;
        int  cyc;
        bit  ok;
        for (int i = 0; i < 3; i++) w[i] = DW'($urandom);
        pulse_start(16'd10);
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_ovf_clear: got %b expected 0", overflow);
        end
        send_warmup(3);
        send_bits(w[0], 15, 0, 3);
        send_bits(w[1], 15, 0, 3);
        send_bits(w[2], 15, 8, 3);
        pulse_stop();
        n_tests++;
        if (clkgen_rstn !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_clkgen_off: got %b expected 0", clkgen_rstn);
        end
        for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(1)), 3);
        wait_done(d0, 5, ok, cyc);
        n_tests++;
        if (beat_d.size() - b0 !== 2 || done_cnt - d0 !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_beats: got %0d beats %0d done busy=%b expected 2 1 0",
                     beat_d.size() - b0, done_cnt - d0, busy);
        end else begin
            n_tests++;
            if (beat_d[b0] !== w[0] || beat_d[b0+1] !== w[1] ||
                beat_l[b0] !== 1'b0 || beat_l[b0+1] !== 1'b0) begin
                n_fail++;
                $display("FAIL stop_data: got %h/%b %h/%b expected %h/0 %h/0",
                         beat_d[b0], beat_l[b0], beat_d[b0+1], beat_l[b0+1], w[0], w[1]);
            end
        end
    endtask

    task automatic test_stop_pending();
        logic [DW-1:0] w = DW'($urandom);
        int  b0 = beat_d.size();
        int  d0 = done_cnt;
        int  cyc;
        bit  ok;
        tr_mode = 0;
        tick();
        pulse_start(16'd5);
        send_warmup(3);
        send_bits(w, 15, 0, 3);
        send_bits(16'h0, 2, 0, 3);
        pulse_stop();
        n_tests++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 || busy !== 1'b1 ||
            clkgen_rstn !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_force_last: got vld=%b last=%b busy=%b clk=%b expected 1 1 1 0",
                     m_axis_tvalid, m_axis_tlast, busy, clkgen_rstn);
        end
        repeat (5) tick();
        n_tests++;
        if (done_cnt !== d0) begin
            n_fail++;
            $display("FAIL pend_flush_wait: got %0d done expected 0", done_cnt - d0);
        end
        tr_mode = 1;
        wait_done(d0, 20, ok, cyc);
        n_tests++;
        if (!ok || beat_d.size() - b0 !== 1) begin
            n_fail++;
            $display("FAIL pend_beats: got %0d beats done=%b expected 1 1", beat_d.size() - b0, ok);
        end else begin
            n_tests++;
            if (beat_d[b0] !== w || beat_l[b0] !== 1'b1) begin
                n_fail++;
                $display("FAIL pend_data: got %h/%b expected %h/1", beat_d[b0], beat_l[b0], w);
            end
        end
    endtask

    task automatic test_zero();
        int  b0 = beat_d.size();
        int  d0 = done_cnt;
        int  cyc;
        bit  ok;
        tick();
        pulse_start(16'd0);
        n_tests++;
        if (clkgen_rstn !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_clkgen: got clk=%b busy=%b expected 0 0", clkgen_rstn, busy);
        end
        wait_done(d0, 10, ok, cyc);
        n_tests++;
        if (!ok || cyc > 2) begin
            n_fail++;
            $display("FAIL zero_done_latency: got %0d cycles done=%b expected <=2 1", cyc, ok);
        end
        repeat (4) tick();
        n_tests++;
        if (beat_d.size() !== b0 || done_cnt - d0 !== 1 || clkgen_rstn !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_no_beats: got %0d beats %0d done expected 0 1",
                     beat_d.size() - b0, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] w = DW'($urandom);
        int  b0;
        int  d0;
        int  cyc;
        bit  ok;
        tr_mode = 0;
        tick();
        pulse_start(16'd3);
        send_warmup(3);
        send_bits(16'h1234, 15, 0, 3);
        tick();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_tests++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || clkgen_rstn !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: got vld=%b busy=%b clk=%b expected 0 0 0",
                     m_axis_tvalid, busy, clkgen_rstn);
        end
        tr_mode = 1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        b0 = beat_d.size();
        d0 = done_cnt;
        pulse_start(16'd1);
        send_warmup(3);
        send_bits(w, 15, 0, 3);
        wait_done(d0, 20, ok, cyc);
        n_tests++;
        if (!ok || beat_d.size() - b0 !== 1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_clean: got %0d beats done=%b ovf=%b expected 1 1 0",
                     beat_d.size() - b0, ok, overflow);
        end else begin
            n_tests++;
            if (beat_d[b0] !== w || beat_l[b0] !== 1'b1) begin
                n_fail++;
                $display("FAIL rstmid_data: got %h/%b expected %h/1", beat_d[b0], beat_l[b0], w);
            end
        end
    endtask

    task automatic test_ignored();
        logic [DW-1:0] w0 = DW'($urandom);
        logic [DW-1:0] w1 = DW'($urandom);
        int  b0 = beat_d.size();
        int  d0 = done_cnt;
        int  cyc;
        bit  ok;
        tick();
        num_words = 16'd3;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        repeat (4) tick();
        n_tests++;
        if (busy !== 1'b0 || clkgen_rstn !== 1'b0 || done_cnt !== d0) begin
            n_fail++;
            $display("FAIL ign_start_stop: got busy=%b clk=%b done=%0d expected 0 0 0",
                     busy, clkgen_rstn, done_cnt - d0);
        end
        pulse_start(16'd2);
        send_warmup(3);
        send_bits(w0, 15, 8, 3);
        pulse_start(16'd0);
        n_tests++;
        if (busy !== 1'b1 || clkgen_rstn !== 1'b1 || done_cnt !== d0) begin
            n_fail++;
            $display("FAIL ign_start_busy: got busy=%b clk=%b done=%0d expected 1 1 0",
                     busy, clkgen_rstn, done_cnt - d0);
        end
        send_bits(w0, 7, 0, 3);
        send_bits(w1, 15, 0, 3);
        wait_done(d0, 20, ok, cyc);
        n_tests++;
        if (!ok || beat_d.size() - b0 !== 2) begin
            n_fail++;
            $display("FAIL ign_beats: got %0d beats done=%b expected 2 1", beat_d.size() - b0, ok);
        end else begin
            n_tests++;
            if (beat_d[b0] !== w0 || beat_d[b0+1] !== w1 || beat_l[b0+1] !== 1'b1) begin
                n_fail++;
                $display("FAIL ign_data: got %h %h/%b expected %h %h/1",
                         beat_d[b0], beat_d[b0+1], beat_l[b0+1], w0, w1);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            logic [DW-1:0] exp_q[$];
            int  n = $urandom_range(4, 1);
            int  period = $urandom_range(6, 3);
            int  b0 = beat_d.size();
            int  d0 = done_cnt;
            int  errs = 0;
            int  cyc;
            bit  ok;
            for (int i = 0; i < n; i++) exp_q.push_back(DW'($urandom));
            tr_mode = 2;
            tick();
            pulse_start(CW'(n));
            send_warmup(period);
            foreach (exp_q[i]) send_bits(exp_q[i], 15, 0, period);
            tr_mode = 1;
            wait_done(d0, 40, ok, cyc);
            n_tests++;
            if (!ok || beat_d.size() - b0 !== n || overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_count: got %0d beats done=%b ovf=%b expected %0d 1 0",
                         it, beat_d.size() - b0, ok, overflow, n);
            end else begin
                for (int i = 0; i < n; i++)
                    if (beat_d[b0+i] !== exp_q[i] || beat_l[b0+i] !== (i == n - 1)) errs++;
                n_tests++;
                if (errs != 0) begin
                    n_fail++;
                    $display("FAIL rand%0d_data: got %0d bad beats expected 0", it, errs);
                end
            end
        end
        n_tests++;
        if (stab_err !== 0) begin
            n_fail++;
            $display("FAIL axis_stability: got %0d violations expected 0", stab_err);
        end
    endtask

    initial begin
        rst           = 1'b0;
        start         = 1'b0;
        stop          = 1'b0;
        num_words     = '0;
        m_clk_rising  = 1'b0;
        pdm_data      = 1'b0;
        m_axis_tready = 1'b1;
        test_reset();
        test_basic();
        test_overflow();
        test_stop();
        test_stop_pending();
        test_zero();
        test_reset_mid();
        test_ignored();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
